// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter/receiver state
// encoding and the baud divisor calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Clock cycles per bit, integer-truncated; callers keep the result >= 4.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BPS_CNT-1 while enabled and flags the wrap
// cycle so the owner can advance to the next bit on that same edge.
module uart_baud_cnt #(
  parameter int BPS_CNT = 434
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int            CW   = $clog2(BPS_CNT);
  localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

  logic [CW-1:0] clk_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the statements are written in.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt_q <= '0;
    end else if (clr_i) begin
      clk_cnt_q <= '0;
    end else if (en_i) begin
      clk_cnt_q <= (clk_cnt_q == LAST) ? '0 : clk_cnt_q + 1'b1;
    end
  end

  assign bit_tick_o = en_i && (clk_cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity and
// 1 or 2 stop bits, launched on a rising edge of send_en while idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam int         BPS_CNT   = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q;
  logic        en_d0_q;
  logic        en_d1_q;
  logic [7:0]  tx_shift_q;
  logic        parity_q;
  logic [2:0]  bit_cnt_q;
  logic        tx_busy_q;
  logic        txd_q;
  logic        start_flag;
  logic        bit_tick;

  assign start_flag = en_d0_q & ~en_d1_q;

  uart_baud_cnt #(
    .BPS_CNT(BPS_CNT)
  ) u_baud_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en_i      (state_q != ST_IDLE),
    .clr_i     (state_q == ST_IDLE),
    .bit_tick_o(bit_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      en_d0_q    <= 1'b0;
      en_d1_q    <= 1'b0;
      tx_shift_q <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      tx_busy_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      en_d0_q <= send_en;
      en_d1_q <= en_d0_q;
      case (state_q)
        ST_IDLE: begin
          if (start_flag) begin
            tx_shift_q <= send_data;
            parity_q   <= (PARITY == PAR_ODD) ? ~^send_data : ^send_data;
            bit_cnt_q  <= '0;
            tx_busy_q  <= 1'b1;
            txd_q      <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            txd_q   <= tx_shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              if (PARITY != PAR_NONE) begin
                txd_q   <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              // Bit 0 is already on the line, so the next bit is shift[1].
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              txd_q      <= tx_shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              tx_busy_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_busy  = tx_busy_q;
  assign uart_txd = txd_q;

endmodule
